// File: rtl/multdiv_ctrl_if.sv
// Issue, multdiv and writeback signal bundle for multdiv_ctrl.
// The master modport is the controller's view; slave is the pipeline/multdiv side.
interface multdiv_ctrl_if;
    logic        issue_valid;
    logic        issue_is_div;
    logic [31:0] issue_a;
    logic [31:0] issue_b;
    logic [4:0]  issue_rd;
    logic        flush;

    logic        md_ctrl_mult;
    logic        md_ctrl_div;
    logic [31:0] md_operand_a;
    logic [31:0] md_operand_b;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;

    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_exception;
    logic        wb_accept;

    modport master (
        input  issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
        input  md_result, md_exception, md_resultRDY, wb_accept,
        output md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
        output stall, wb_valid, wb_rd, wb_data, wb_exception
    );

    modport slave (
        output issue_valid, issue_is_div, issue_a, issue_b, issue_rd, flush,
        output md_result, md_exception, md_resultRDY, wb_accept,
        input  md_ctrl_mult, md_ctrl_div, md_operand_a, md_operand_b,
        input  stall, wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// Sequencer for the iterative multiply/divide unit: issue capture, start pulse, stall, writeback.
// Optional BUSY watchdog compiled in with `define MULTDIV_TIMEOUT_EN.
module multdiv_ctrl #(
    parameter int         TIMEOUT_CYCLES = 40,
    parameter logic [4:0] RSTATUS_REG    = 5'd30
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.master bus
);
    typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_e;

    state_e      state_q, state_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [4:0]  rd_q, rd_d;
    logic        is_div_q, is_div_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_exc_q, wb_exc_d;
    logic [31:0] exc_code;

    // rstatus code: 4 for a failed mul, 5 for a failed div
    assign exc_code = is_div_q ? 32'd5 : 32'd4;

`ifdef MULTDIV_TIMEOUT_EN
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`else
    logic unused_timeout;
    assign unused_timeout = |TIMEOUT_CYCLES;
`endif

    always_comb begin
        // NOTE: every variable gets a hold default first so no path infers a latch.
        state_d   = state_q;
        opa_d     = opa_q;
        opb_d     = opb_q;
        rd_d      = rd_q;
        is_div_d  = is_div_q;
        wb_rd_d   = wb_rd_q;
        wb_data_d = wb_data_q;
        wb_exc_d  = wb_exc_q;
`ifdef MULTDIV_TIMEOUT_EN
        cnt_d     = cnt_q;
`endif
        if (bus.flush) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.issue_valid) begin
                        opa_d    = bus.issue_a;
                        opb_d    = bus.issue_b;
                        rd_d     = bus.issue_rd;
                        is_div_d = bus.issue_is_div;
                        state_d  = START;
                    end
                end
                START: begin
                    // RDY here may be left over from the previous operation
                    state_d = BUSY;
`ifdef MULTDIV_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
                BUSY: begin
                    if (bus.md_resultRDY) begin
                        state_d = DONE;
                        if (bus.md_exception) begin
                            wb_rd_d   = RSTATUS_REG;
                            wb_data_d = exc_code;
                            wb_exc_d  = 1'b1;
                        end else begin
                            wb_rd_d   = rd_q;
                            wb_data_d = bus.md_result;
                            wb_exc_d  = 1'b0;
                        end
                    end
`ifdef MULTDIV_TIMEOUT_EN
                    else if (cnt_q == TIMEOUT_LAST) begin
                        state_d   = DONE;
                        wb_rd_d   = RSTATUS_REG;
                        wb_data_d = exc_code;
                        wb_exc_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
`endif
                end
                DONE: begin
                    if (bus.wb_accept) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (reset) begin
            state_q   <= IDLE;
            opa_q     <= '0;
            opb_q     <= '0;
            rd_q      <= '0;
            is_div_q  <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_exc_q  <= 1'b0;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            rd_q      <= rd_d;
            is_div_q  <= is_div_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_exc_q  <= wb_exc_d;
`ifdef MULTDIV_TIMEOUT_EN
            cnt_q     <= cnt_d;
`endif
        end
    end

    // Flush kills the pulses, the writeback request and the stall in the same cycle
    assign bus.md_ctrl_mult = (state_q == START) && !is_div_q && !bus.flush;
    assign bus.md_ctrl_div  = (state_q == START) &&  is_div_q && !bus.flush;
    assign bus.md_operand_a = opa_q;
    assign bus.md_operand_b = opb_q;
    assign bus.wb_valid     = (state_q == DONE) && !bus.flush;
    assign bus.wb_rd        = wb_rd_q;
    assign bus.wb_data      = wb_data_q;
    assign bus.wb_exception = wb_exc_q;
    assign bus.stall        = !bus.flush &&
                              (((state_q == IDLE) && bus.issue_valid) ||
                               (state_q == START) || (state_q == BUSY) ||
                               ((state_q == DONE) && !bus.wb_accept));
endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: hand-computed expectations checked with immediate assertions.
module tb_multdiv_ctrl;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    multdiv_ctrl_if bus ();
    multdiv_ctrl dut (.clock(clock), .reset(reset), .bus(bus));

    int tests = 0;
    int fails = 0;
    int n_mult = 0;
    int n_div = 0;
    int bad;
    int snap;

    always @(negedge clock) begin
        if (bus.md_ctrl_mult === 1'b1) n_mult++;
        if (bus.md_ctrl_div === 1'b1) n_div++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic idle_inputs();
        bus.issue_valid  = 1'b0;
        bus.issue_is_div = 1'b0;
        bus.issue_a      = '0;
        bus.issue_b      = '0;
        bus.issue_rd     = '0;
        bus.flush        = 1'b0;
        bus.md_result    = '0;
        bus.md_exception = 1'b0;
        bus.md_resultRDY = 1'b0;
        bus.wb_accept    = 1'b0;
    endtask

    task automatic issue(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
        bus.issue_valid  = 1'b1;
        bus.issue_is_div = is_div;
        bus.issue_a      = a;
        bus.issue_b      = b;
        bus.issue_rd     = rd;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        check("rst_stall", bus.stall, 0);
        check("rst_wb", {bus.wb_valid, bus.wb_exception, bus.wb_rd}, 0);
        check("rst_wb_data", bus.wb_data, 0);
        check("rst_ops", bus.md_operand_a | bus.md_operand_b, 0);
        check("rst_pulses", {bus.md_ctrl_mult, bus.md_ctrl_div}, 0);

        // Mul 6x7 -> r3, RDY at cycle 33, immediate accept
        snap = n_mult;
        issue(1'b0, 32'd6, 32'd7, 5'd3);
        #1 check("t1_stall_issue", bus.stall, 1);
        tick(); bus.issue_valid = 1'b0;
        #1 check("t1_pulses", {bus.md_ctrl_mult, bus.md_ctrl_div}, 2'b10);
        check("t1_opa", bus.md_operand_a, 6);
        check("t1_opb", bus.md_operand_b, 7);
        check("t1_stall_start", bus.stall, 1);
        tick();
        bad = 0;
        for (int c = 2; c <= 32; c++) begin
            #1;
            if (bus.stall !== 1'b1 || bus.wb_valid !== 1'b0 || bus.md_ctrl_mult !== 1'b0 ||
                bus.md_operand_a !== 32'd6 || bus.md_operand_b !== 32'd7) bad++;
            tick();
        end
        check("t1_busy_hold", bad, 0);
        bus.md_resultRDY = 1'b1; bus.md_result = 32'd42;
        #1 check("t1_stall_rdy", bus.stall, 1);
        tick(); bus.md_resultRDY = 1'b0; bus.md_result = '0; bus.wb_accept = 1'b1;
        #1 check("t1_wb_valid", bus.wb_valid, 1);
        check("t1_wb_rd", bus.wb_rd, 3);
        check("t1_wb_data", bus.wb_data, 42);
        check("t1_wb_exc", bus.wb_exception, 0);
        check("t1_stall_accept", bus.stall, 0);
        check("t1_mult_pulses", n_mult - snap, 1);
        tick(); bus.wb_accept = 1'b0;
        #1 check("t1_idle", {bus.wb_valid, bus.stall}, 0);

        // Back-to-back: div 1/0 -> r4 with exception, minimum latency
        issue(1'b1, 32'd1, 32'd0, 5'd4);
        #1 check("t2_stall_issue", bus.stall, 1);
        tick(); bus.issue_valid = 1'b0;
        #1 check("t2_pulses", {bus.md_ctrl_mult, bus.md_ctrl_div}, 2'b01);
        tick();
        bus.md_resultRDY = 1'b1; bus.md_exception = 1'b1; bus.md_result = 32'hdeadbeef;
        tick();
        bus.md_resultRDY = 1'b0; bus.md_exception = 1'b0; bus.wb_accept = 1'b1;
        #1 check("t2_wb_valid", bus.wb_valid, 1);
        check("t2_wb_rd", bus.wb_rd, 30);
        check("t2_wb_data", bus.wb_data, 5);
        check("t2_wb_exc", bus.wb_exception, 1);
        tick(); bus.wb_accept = 1'b0;

        // RDY ignored in IDLE and START; accept held low 3 cycles
        bus.md_resultRDY = 1'b1; bus.md_result = 32'd100;
        tick();
        #1 check("t3_idle_rdy", {bus.wb_valid, bus.stall}, 0);
        issue(1'b0, 32'd10, 32'd10, 5'd7);
        tick(); bus.issue_valid = 1'b0;
        #1 check("t3_pulse", bus.md_ctrl_mult, 1);
        tick();
        #1 check("t3_stale_rdy", {bus.wb_valid, bus.stall}, 2'b01);
        tick(); bus.md_resultRDY = 1'b0; bus.md_result = '0;
        bad = 0;
        for (int c = 0; c < 3; c++) begin
            #1;
            if (bus.wb_valid !== 1'b1 || bus.wb_data !== 32'd100 || bus.wb_rd !== 5'd7 ||
                bus.wb_exception !== 1'b0 || bus.stall !== 1'b1) bad++;
            tick();
        end
        check("t3_done_hold", bad, 0);
        bus.wb_accept = 1'b1;
        #1 check("t3_accept_valid", bus.wb_valid, 1);
        check("t3_accept_data", bus.wb_data, 100);
        check("t3_accept_stall", bus.stall, 0);
        tick(); bus.wb_accept = 1'b0;
        #1 check("t3_idle", {bus.wb_valid, bus.stall}, 0);

        // Flush in 5th BUSY cycle, late RDY 10 cycles later
        issue(1'b0, 32'd3, 32'd5, 5'd2);
        tick(); bus.issue_valid = 1'b0;
        tick();
        repeat (4) tick();
        bus.flush = 1'b1;
        #1 check("t4_flush_cycle", {bus.stall, bus.wb_valid}, 0);
        tick(); bus.flush = 1'b0;
        bad = 0;
        for (int c = 0; c < 9; c++) begin
            #1;
            if (bus.stall !== 1'b0 || bus.wb_valid !== 1'b0) bad++;
            tick();
        end
        bus.md_resultRDY = 1'b1; bus.md_result = 32'd15;
        tick(); bus.md_resultRDY = 1'b0; bus.md_result = '0;
        #1 check("t4_late_rdy", {bus.stall, bus.wb_valid}, 0);
        check("t4_after_flush", bad, 0);

        // Flush and issue together: nothing captured
        snap = n_mult;
        issue(1'b0, 32'd9, 32'd9, 5'd1);
        bus.flush = 1'b1;
        #1 check("t4b_stall", bus.stall, 0);
        tick(); bus.issue_valid = 1'b0; bus.flush = 1'b0;
        #1 check("t4b_no_start", {bus.md_ctrl_mult, bus.stall}, 0);
        tick();
        check("t4b_no_pulse", n_mult - snap, 0);

        // RDY never arrives
        issue(1'b0, 32'd2, 32'd3, 5'd5);
        tick(); bus.issue_valid = 1'b0;
        tick();
        bad = 0;
`ifdef MULTDIV_TIMEOUT_EN
        for (int c = 0; c < 40; c++) begin
            #1;
            if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b1) bad++;
            tick();
        end
        check("t5_busy_40", bad, 0);
        #1 check("t5_to_valid", bus.wb_valid, 1);
        check("t5_to_rd", bus.wb_rd, 30);
        check("t5_to_data", bus.wb_data, 4);
        check("t5_to_exc", bus.wb_exception, 1);
        bus.wb_accept = 1'b1;
        tick(); bus.wb_accept = 1'b0;
`else
        for (int c = 0; c < 100; c++) begin
            #1;
            if (bus.wb_valid !== 1'b0 || bus.stall !== 1'b1) bad++;
            tick();
        end
        check("t5_busy_100", bad, 0);
        bus.flush = 1'b1;
        tick(); bus.flush = 1'b0;
`endif
        #1 check("t5_idle", {bus.wb_valid, bus.stall}, 0);

        // Reset during BUSY, then immediate div
        issue(1'b1, 32'd50, 32'd0, 5'd8);
        tick(); bus.issue_valid = 1'b0;
        repeat (3) tick();
        reset = 1'b1;
        tick(); reset = 1'b0;
        #1 check("t6_rst_ctl", {bus.stall, bus.wb_valid, bus.wb_exception,
                                bus.md_ctrl_mult, bus.md_ctrl_div}, 0);
        check("t6_rst_wb", {bus.wb_rd, bus.wb_data}, 0);
        check("t6_rst_ops", bus.md_operand_a | bus.md_operand_b, 0);
        snap = n_div;
        issue(1'b1, 32'd100, 32'd7, 5'd9);
        tick(); bus.issue_valid = 1'b0;
        #1 check("t6_pulse", {bus.md_ctrl_mult, bus.md_ctrl_div}, 2'b01);
        check("t6_opa", bus.md_operand_a, 100);
        tick();
        bus.md_resultRDY = 1'b1; bus.md_result = 32'd14;
        tick(); bus.md_resultRDY = 1'b0; bus.md_result = '0; bus.wb_accept = 1'b1;
        #1 check("t6_wb_valid", bus.wb_valid, 1);
        check("t6_wb_rd", bus.wb_rd, 9);
        check("t6_wb_data", bus.wb_data, 14);
        check("t6_wb_exc", bus.wb_exception, 0);
        tick(); bus.wb_accept = 1'b0;
        #1 check("t6_div_pulses", n_div - snap, 1);
        check("t6_idle", {bus.wb_valid, bus.stall}, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
